// File: rtl/irq_rr_sched.sv
// irq_rr_sched: round-robin interrupt scheduler for an XDMA-style user-IRQ request/ack channel
//
// Latches rising edges on NUM_SRC interrupt sources. It then serves the pending, unmasked
// sources one at a time in round-robin order. Only one request is outstanding at any time.
// A failed request is re-issued after a fixed idle backoff. After RETRY_MAX re-issues that
// also fail, the request is abandoned and drop_err pulses.
//
// Optional feature: define IRQ_SCHED_TIMEOUT_EN to treat TIMEOUT_CYC cycles in REQ without
// ack/fail as a fail. Without it the request waits indefinitely.
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous reset, active low
//   src_irq      in   per-source interrupt level; a 0->1 transition posts an event
//   src_mask     in   1 = source ineligible for grant (events still latched)
//   irq_req_vld  out  request valid, held until irq_ack or irq_fail
//   irq_req_vec  out  index of the granted source, stable while irq_req_vld=1
//   irq_req_fnc  out  constant FNC
//   irq_ack      in   1-cycle pulse: request accepted
//   irq_fail     in   1-cycle pulse: request rejected
//   pending      out  latched, not-yet-delivered events
//   drop_err     out  1-cycle pulse when a request is abandoned
//   busy         out  1 while the scheduler is not idle
module irq_rr_sched #(
    parameter int          NUM_SRC     = 16,
    parameter int          VEC_W       = 5,
    parameter logic [7:0]  FNC         = 8'h00,
    parameter int          RETRY_MAX   = 3,
    parameter int          BACKOFF_CYC = 16,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic [NUM_SRC-1:0] src_mask,
    output logic               irq_req_vld,
    output logic [VEC_W-1:0]   irq_req_vec,
    output logic [7:0]         irq_req_fnc,
    input  logic               irq_ack,
    input  logic               irq_fail,
    output logic [NUM_SRC-1:0] pending,
    output logic               drop_err,
    output logic               busy
);
    localparam int BO_W = $clog2(BACKOFF_CYC + 1);
    localparam int RT_W = $clog2(RETRY_MAX + 2);
    localparam logic [VEC_W:0] NS = (VEC_W + 1)'(NUM_SRC);

    typedef enum logic [1:0] {IDLE, REQ, BACKOFF} state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] src_q, pending_q, pending_d;
    logic [VEC_W-1:0]   vec_q, vec_d, rr_ptr_q, rr_ptr_d;
    logic [RT_W-1:0]    retry_q, retry_d;
    logic [BO_W-1:0]    bo_q, bo_d;
    logic               vld_q, vld_d, drop_q, drop_d, busy_q, busy_d;

    logic [NUM_SRC-1:0] set, clr, eligible, rot;
    logic [VEC_W-1:0]   first, grant, vec_nxt;
    logic [VEC_W:0]     sum;
    logic               tmo_hit, fail_ev;

    assign set      = src_irq & ~src_q;
    assign eligible = pending_q & ~src_mask;
    // Set is OR-ed in after the clear, so a new edge on the source being retired re-posts it.
    assign pending_d = (pending_q & ~clr) | set;

`ifdef IRQ_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    // Counts cycles spent in the current REQ visit; any other state restarts it at zero.
    assign tmo_d   = (state_q == REQ) ? tmo_q + 1'b1 : '0;
    assign tmo_hit = (state_q == REQ) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
    logic unused_tmo;
    assign unused_tmo = |TIMEOUT_CYC;
    assign tmo_hit    = 1'b0;
`endif

    assign fail_ev = irq_fail | tmo_hit;

    // Round-robin search: rotate so that rr_ptr lands on bit 0, then pick the lowest set bit.
    // Map that bit back to a source index.
    always_comb begin
        rot   = NUM_SRC'({eligible, eligible} >> rr_ptr_q);
        first = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (rot[i]) first = VEC_W'(i);
        end
        sum   = {1'b0, rr_ptr_q} + {1'b0, first};
        grant = (sum >= NS) ? VEC_W'(sum - NS) : VEC_W'(sum);
    end

    assign vec_nxt = (vec_q == VEC_W'(NUM_SRC - 1)) ? '0 : vec_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        rr_ptr_d = rr_ptr_q;
        retry_d  = retry_q;
        bo_d     = bo_q;
        clr      = '0;
        drop_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = REQ;
                    vec_d   = grant;
                    retry_d = '0;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    clr      = NUM_SRC'(1) << vec_q;
                    rr_ptr_d = vec_nxt;
                    state_d  = IDLE;
                end else if (fail_ev) begin
                    if (retry_q == RT_W'(RETRY_MAX)) begin
                        clr      = NUM_SRC'(1) << vec_q;
                        drop_d   = 1'b1;
                        rr_ptr_d = vec_nxt;
                        state_d  = IDLE;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        // The fail edge itself starts the first idle cycle, hence the -1.
                        bo_d    = BO_W'(BACKOFF_CYC - 1);
                        state_d = BACKOFF;
                    end
                end
            end
            BACKOFF: begin
                if (bo_q == '0) state_d = REQ;
                else            bo_d    = bo_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        vld_d  = state_d == REQ;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            src_q     <= '0;
            pending_q <= '0;
            vec_q     <= '0;
            rr_ptr_q  <= '0;
            retry_q   <= '0;
            bo_q      <= '0;
            vld_q     <= 1'b0;
            drop_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef IRQ_SCHED_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            src_q     <= src_irq;
            pending_q <= pending_d;
            vec_q     <= vec_d;
            rr_ptr_q  <= rr_ptr_d;
            retry_q   <= retry_d;
            bo_q      <= bo_d;
            vld_q     <= vld_d;
            drop_q    <= drop_d;
            busy_q    <= busy_d;
`ifdef IRQ_SCHED_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign irq_req_vld = vld_q;
    assign irq_req_vec = vec_q;
    assign irq_req_fnc = FNC;
    assign pending     = pending_q;
    assign drop_err    = drop_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_irq_rr_sched.sv
// tb_irq_rr_sched: directed-vector self-checking bench for irq_rr_sched
module tb_irq_rr_sched;
    localparam logic [7:0] FNC = 8'h5a;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] src_irq = '0;
    logic [15:0] src_mask = '0;
    logic        irq_ack = 1'b0;
    logic        irq_fail = 1'b0;
    logic        irq_req_vld;
    logic [4:0]  irq_req_vec;
    logic [7:0]  irq_req_fnc;
    logic [15:0] pending;
    logic        drop_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    irq_rr_sched #(
        .NUM_SRC(16), .VEC_W(5), .FNC(FNC), .RETRY_MAX(3), .BACKOFF_CYC(16), .TIMEOUT_CYC(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .src_irq(src_irq), .src_mask(src_mask),
        .irq_req_vld(irq_req_vld), .irq_req_vec(irq_req_vec), .irq_req_fnc(irq_req_fnc),
        .irq_ack(irq_ack), .irq_fail(irq_fail), .pending(pending),
        .drop_err(drop_err), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        src_irq  = '0;
        src_mask = '0;
        irq_ack  = 1'b0;
        irq_fail = 1'b0;
        rst_n    = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic pulse_src(input logic [15:0] m);
        src_irq = src_irq | m;
        tick;
        src_irq = src_irq & ~m;
    endtask

    task automatic wait_vld(input string tag);
        int n = 0;
        while (!irq_req_vld && n < 100) begin
            tick;
            n++;
        end
        check({tag, "_vld"}, 32'(irq_req_vld), 1);
    endtask

    task automatic serve(input logic [4:0] v, input string tag);
        wait_vld(tag);
        check({tag, "_vec"}, 32'(irq_req_vec), 32'(v));
        irq_ack = 1'b1;
        tick;
        irq_ack = 1'b0;
        check({tag, "_vld_after_ack"}, 32'(irq_req_vld), 0);
    endtask

    task automatic retry_seq(input logic [4:0] v, input int hi_cyc, input string tag);
        int n;
        for (int k = 0; k < 4; k++) begin
            wait_vld(tag);
            check({tag, "_vec"}, 32'(irq_req_vec), 32'(v));
            check({tag, "_no_drop"}, 32'(drop_err), 0);
            if (hi_cyc == 0) begin
                irq_fail = 1'b1;
                tick;
                irq_fail = 1'b0;
            end else begin
                n = 0;
                while (irq_req_vld && n < 200) begin
                    n++;
                    tick;
                end
                check({tag, "_hi_cycles"}, 32'(n), 32'(hi_cyc));
            end
            check({tag, "_vld_low"}, 32'(irq_req_vld), 0);
            if (k < 3) begin
                check({tag, "_busy_backoff"}, 32'(busy), 1);
                n = 0;
                while (!irq_req_vld && n < 100) begin
                    n++;
                    tick;
                end
                check({tag, "_gap"}, 32'(n), 16);
            end else begin
                check({tag, "_drop"}, 32'(drop_err), 1);
                check({tag, "_pend"}, 32'(pending), 0);
                check({tag, "_busy"}, 32'(busy), 0);
                tick;
                check({tag, "_drop_pulse"}, 32'(drop_err), 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] rr_exp [8] = '{5'd1, 5'd3, 5'd5, 5'd7, 5'd8, 5'd10, 5'd12, 5'd14};

        tick;
        check("rst_vld", 32'(irq_req_vld), 0);
        check("rst_vec", 32'(irq_req_vec), 0);
        check("rst_pend", 32'(pending), 0);
        check("rst_drop", 32'(drop_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fnc", 32'(irq_req_fnc), 32'(FNC));
        rst_n = 1'b1;
        tick;

        // single request: src 3, acked two cycles after vld
        src_irq = 16'h0008;
        tick;
        check("t1_pend", 32'(pending), 32'h8);
        check("t1_vld_lat", 32'(irq_req_vld), 0);
        tick;
        check("t1_vld", 32'(irq_req_vld), 1);
        check("t1_vec", 32'(irq_req_vec), 3);
        check("t1_fnc", 32'(irq_req_fnc), 32'(FNC));
        check("t1_busy", 32'(busy), 1);
        tick;
        tick;
        check("t1_vld_hold", 32'(irq_req_vld), 1);
        irq_ack = 1'b1;
        tick;
        irq_ack = 1'b0;
        check("t1_vld_ack", 32'(irq_req_vld), 0);
        check("t1_pend_ack", 32'(pending), 0);
        check("t1_busy_ack", 32'(busy), 0);
        // rr_ptr is now 4: with 2 and 5 pending, 5 goes first
        pulse_src(16'h0024);
        serve(5'd5, "t1_rr_a");
        serve(5'd2, "t1_rr_b");

        // round robin across 16'h55aa
        do_reset;
        src_irq = 16'h55aa;
        tick;
        src_irq = '0;
        for (int i = 0; i < 8; i++) serve(rr_exp[i], $sformatf("t2_rr%0d", i));
        check("t2_pend", 32'(pending), 0);

        // retry then drop on src 0
        do_reset;
        pulse_src(16'h0001);
        retry_seq(5'd0, 0, "t3");

        // masking
        do_reset;
        src_mask = 16'h0002;
        pulse_src(16'h0006);
        serve(5'd2, "t4_a");
        repeat (4) tick;
        check("t4_vld_masked", 32'(irq_req_vld), 0);
        check("t4_pend_masked", 32'(pending), 32'h2);
        src_mask = '0;
        serve(5'd1, "t4_b");
        check("t4_pend", 32'(pending), 0);

        // re-post: edge on src 4 in the ack cycle
        do_reset;
        pulse_src(16'h0010);
        wait_vld("t5_a");
        check("t5_vec", 32'(irq_req_vec), 4);
        src_irq = 16'h0010;
        irq_ack = 1'b1;
        tick;
        irq_ack = 1'b0;
        src_irq = '0;
        check("t5_repost", 32'(pending), 32'h10);
        serve(5'd4, "t5_b");
        check("t5_pend", 32'(pending), 0);

        // reset during REQ with levels held
        do_reset;
        src_irq = 16'h0009;
        wait_vld("t6_a");
        check("t6_vec", 32'(irq_req_vec), 0);
        rst_n = 1'b0;
        #1;
        check("t6_vld_async", 32'(irq_req_vld), 0);
        check("t6_pend_async", 32'(pending), 0);
        check("t6_busy_async", 32'(busy), 0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        check("t6_repost", 32'(pending), 32'h9);
        serve(5'd0, "t6_b");
        serve(5'd3, "t6_c");
        check("t6_pend", 32'(pending), 0);
        src_irq = '0;

`ifdef IRQ_SCHED_TIMEOUT_EN
        // no ack/fail: each request times out after 32 cycles
        do_reset;
        pulse_src(16'h0040);
        retry_seq(5'd6, 32, "t7");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
